// File: rtl/vend_pkg.sv
// Shared definitions for the newspaper vending machine and its coin acceptor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vend_pkg;

    // Coin codes presented to the vending machine FSM. 2'b11 is never driven.
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    // Coin acceptor state encoding.
    typedef enum logic [2:0] {
        ACC_IDLE     = 3'd0,
        ACC_QUALIFY  = 3'd1,
        ACC_HELD     = 3'd2,
        ACC_ISSUE    = 3'd3,
        ACC_GAP      = 3'd4,
        ACC_REJ      = 3'd5,
        ACC_JAM      = 3'd6,
        ACC_WAIT_CLR = 3'd7
    } acc_state_t;

    // Vending machine credit memory encoding (credit accumulated so far).
    typedef enum logic [1:0] {
        MEM_0  = 2'd0,
        MEM_5  = 2'd1,
        MEM_10 = 2'd2,
        MEM_15 = 2'd3
    } mem_t;

    // Coin code for a single-sensor event: nickel sensor wins when it is the one high.
    function automatic logic [1:0] coin_of(input logic nickel_hi);
        return nickel_hi ? COIN_5 : COIN_10;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous level input.
// Latency: 2 clk cycles from input change to sync_o.
// Backpressure: none; free-running.
module sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Debounces nickel/dime sensors and emits one coin code pulse per valid insertion.
// Latency: coin pulse 3 clk edges after the first edge that samples the raw sensor low.
// Backpressure: none; consumer samples coin every cycle, pulses are not held.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int JAM_CYCLES      = 4096,
    parameter int GAP_CYCLES      = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       nickel_raw,
    input  logic       dime_raw,
    input  logic       enable,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam
);

    import vend_pkg::*;

    localparam int CNT_W = $clog2(JAM_CYCLES);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] JAM_LAST  = CNT_W'(JAM_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    logic             n_s;
    logic             d_s;
    acc_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_sat_d;
    logic [1:0]       kind_q;
    logic             en_q;
    logic [1:0]       coin_q;
    logic             reject_q;
    logic             jam_q;
    logic             latched_hi;
    logic             other_hi;
    logic             any_hi;

    sync2 u_sync_nickel (
        .clk     (clk),
        .rstn    (rstn),
        .async_i (nickel_raw),
        .sync_o  (n_s)
    );

    sync2 u_sync_dime (
        .clk     (clk),
        .rstn    (rstn),
        .async_i (dime_raw),
        .sync_o  (d_s)
    );

    // Sensor views relative to the coin currently being tracked, plus saturating count.
    always_comb begin
        latched_hi = (kind_q == COIN_5) ? n_s : d_s;
        other_hi   = (kind_q == COIN_5) ? d_s : n_s;
        any_hi     = n_s | d_s;
        cnt_sat_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Acceptor FSM; outputs are registered alongside the state transition that produces them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ACC_IDLE;
            cnt_q    <= '0;
            kind_q   <= COIN_NONE;
            en_q     <= 1'b0;
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
        end else begin
            // Pulse outputs default low; only ISSUE and REJ raise them for one cycle.
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;

            case (state_q)
                ACC_IDLE: begin
                    if (n_s && d_s) begin
                        // Both chutes active together: collision, never credited.
                        state_q <= ACC_REJ;
                    end else if (any_hi) begin
                        kind_q  <= coin_of(n_s);
                        cnt_q   <= '0;
                        state_q <= ACC_QUALIFY;
                    end
                end

                ACC_QUALIFY: begin
                    if (other_hi) begin
                        state_q <= ACC_REJ;
                    end else if (!latched_hi) begin
                        // Dropped before the debounce window filled: glitch, no output.
                        state_q <= ACC_IDLE;
                    end else begin
                        cnt_q <= cnt_sat_d;
                        if (cnt_sat_d == QUAL_LAST) begin
                            state_q <= ACC_HELD;
                        end
                    end
                end

                ACC_HELD: begin
                    if (other_hi) begin
                        state_q <= ACC_REJ;
                    end else if (!latched_hi) begin
                        // Coin has left the chute; enable is captured on this edge only.
                        en_q    <= enable;
                        state_q <= ACC_ISSUE;
                    end else begin
                        cnt_q <= cnt_sat_d;
                        if (cnt_sat_d == JAM_LAST) begin
                            cnt_q   <= '0;
                            jam_q   <= 1'b1;
                            state_q <= ACC_JAM;
                        end
                    end
                end

                ACC_ISSUE: begin
                    if (en_q) begin
                        coin_q <= kind_q;
                    end else begin
                        reject_q <= 1'b1;
                    end
                    cnt_q   <= '0;
                    state_q <= ACC_GAP;
                end

                ACC_GAP: begin
                    // Lockout: sensors ignored until the gap has elapsed.
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ACC_IDLE;
                    end else begin
                        cnt_q <= cnt_sat_d;
                    end
                end

                ACC_REJ: begin
                    reject_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= ACC_WAIT_CLR;
                end

                ACC_JAM: begin
                    cnt_q   <= '0;
                    state_q <= ACC_WAIT_CLR;
                end

                ACC_WAIT_CLR: begin
                    // Chute must read empty for a full debounce window before re-arming.
                    if (any_hi) begin
                        cnt_q <= '0;
                    end else if (cnt_q == QUAL_LAST) begin
                        cnt_q   <= '0;
                        jam_q   <= 1'b0;
                        state_q <= ACC_GAP;
                    end else begin
                        cnt_q <= cnt_sat_d;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    state_q <= ACC_IDLE;
                end
            endcase
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign jam    = jam_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus pushes expected events, a monitor pops them.
// Latency: expectations are stated in clock edges counted from the stimulus cycle.
// Backpressure: none; outputs are checked every cycle on the falling edge.
module tb_coin_acceptor;

    localparam int D = 4;
    localparam int J = 20;
    localparam int G = 2;

    // Event kinds seen on the outputs; coin kinds double as sensor selectors.
    localparam int EV_N    = 1;
    localparam int EV_D    = 2;
    localparam int EV_REJ  = 3;
    localparam int EV_JON  = 4;
    localparam int EV_JOFF = 5;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       nickel_raw = 1'b0;
    logic       dime_raw = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] coin;
    logic       reject;
    logic       jam;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    exp_t exq[$];
    logic jam_prev = 1'b0;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (D),
        .JAM_CYCLES      (J),
        .GAP_CYCLES      (G)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .nickel_raw (nickel_raw),
        .dime_raw   (dime_raw),
        .enable     (enable),
        .coin       (coin),
        .reject     (reject),
        .jam        (jam)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        exq.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic seen(input int kind);
        exp_t e;
        n_cmp++;
        if (exq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d at edge %0d, expected no event", kind, cyc);
        end else begin
            e = exq.pop_front();
            if (e.kind != kind || e.at != cyc) begin
                n_bad++;
                $display("FAIL event: got kind %0d at edge %0d, expected kind %0d at edge %0d",
                         kind, cyc, e.kind, e.at);
            end
        end
    endtask

    task automatic drain(input string name);
        chk(name, exq.size(), 0);
        exq.delete();
    endtask

    task automatic set_raw(input int k, input logic v);
        if (k == EV_N) nickel_raw = v;
        else           dime_raw   = v;
    endtask

    // One sensor high for L sampled cycles; enable forced to en_issue only around the capture edge.
    task automatic single(input int k, input int L, input logic en_issue, input logic en_other);
        int c;
        c = cyc;
        enable = en_other;
        set_raw(k, 1'b1);
        if (L >= D && L <= J - 1) begin
            expect_ev(en_issue ? k : EV_REJ, c + L + 4);
        end else if (L > J) begin
            expect_ev(EV_JON, c + 2 + J);
            expect_ev(EV_JOFF, c + L + D + 2);
        end
        tick(L);
        set_raw(k, 1'b0);
        tick(2);
        enable = en_issue;
        tick(1);
        enable = en_other;
        tick(40);
        drain("single_pending");
    endtask

    // Both sensors rise together.
    task automatic collide(input int L);
        int c;
        c = cyc;
        nickel_raw = 1'b1;
        dime_raw   = 1'b1;
        expect_ev(EV_REJ, c + 4);
        tick(L);
        nickel_raw = 1'b0;
        dime_raw   = 1'b0;
        tick(40);
        drain("collide_pending");
    endtask

    // Second sensor rises o cycles after the first while the first is still high.
    task automatic offset(input int k, input int o, input int x, input int y);
        int c;
        int k2;
        c  = cyc;
        k2 = (k == EV_N) ? EV_D : EV_N;
        set_raw(k, 1'b1);
        expect_ev(EV_REJ, c + o + 4);
        tick(o);
        set_raw(k2, 1'b1);
        tick(x);
        set_raw(k, 1'b0);
        tick(y);
        set_raw(k2, 1'b0);
        tick(40);
        drain("offset_pending");
    endtask

    // Monitor: every observed output event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rstn) begin
            jam_prev = 1'b0;
        end else begin
            if (coin != 2'b00 || reject) begin
                n_cmp++;
                if (coin == 2'b11 || (coin != 2'b00 && reject)) begin
                    n_bad++;
                    $display("FAIL illegal_output: got coin=%b reject=%b, expected exclusive legal code",
                             coin, reject);
                end
            end
            if (coin == 2'b01)      seen(EV_N);
            else if (coin == 2'b10) seen(EV_D);
            if (reject)             seen(EV_REJ);
            if (jam && !jam_prev)   seen(EV_JON);
            if (!jam && jam_prev)   seen(EV_JOFF);
            jam_prev = jam;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int sel;
        int k;
        int c2;

        // Reset state, during and after reset.
        tick(3);
        chk("rst_coin", coin, 0);
        chk("rst_reject", reject, 0);
        chk("rst_jam", jam, 0);
        rstn = 1'b1;
        tick(3);
        chk("idle_coin", coin, 0);
        chk("idle_jam", jam, 0);

        // Directed cases.
        single(EV_N, 10, 1'b1, 1'b1);          // plain nickel
        single(EV_D, 2, 1'b1, 1'b1);           // dime glitch
        single(EV_D, 6, 1'b1, 1'b1);           // valid dime after glitch
        collide(6);                            // simultaneous rise
        single(EV_D, 30, 1'b1, 1'b1);          // jam and recovery
        single(EV_N, 5, 1'b1, 1'b1);           // credited after jam
        single(EV_N, 8, 1'b0, 1'b1);           // enable low only at capture edge
        single(EV_D, 8, 1'b1, 1'b0);           // enable high only at capture edge
        single(EV_N, D, 1'b1, 1'b1);           // shortest coin
        single(EV_N, D - 1, 1'b1, 1'b1);       // longest glitch
        single(EV_D, J - 1, 1'b1, 1'b1);       // longest non-jam
        single(EV_N, J + 1, 1'b1, 1'b1);       // shortest jam checked here
        offset(EV_N, 2, 2, 3);                 // dime arrives during qualify
        offset(EV_D, D + 3, 2, 2);             // nickel arrives during held

        // Reset while a nickel is held: outputs clear, coin re-qualifies once.
        nickel_raw = 1'b1;
        tick(D + 6);
        rstn = 1'b0;
        #1;
        chk("held_rst_coin", coin, 0);
        chk("held_rst_reject", reject, 0);
        chk("held_rst_jam", jam, 0);
        tick(3);
        rstn = 1'b1;
        c2 = cyc;
        expect_ev(EV_N, c2 + 6 + 4);
        tick(6);
        nickel_raw = 1'b0;
        tick(40);
        drain("held_rst_pending");

        // Reset while jammed: jam drops immediately.
        c2 = cyc;
        dime_raw = 1'b1;
        expect_ev(EV_JON, c2 + 2 + J);
        tick(J + 5);
        chk("jam_level", jam, 1);
        rstn = 1'b0;
        #1;
        chk("jam_rst", jam, 0);
        dime_raw = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(40);
        drain("jam_rst_pending");

        // Randomised insertions.
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 4);
            k   = ($urandom_range(0, 1) == 0) ? EV_N : EV_D;
            case (sel)
                0: single(k, $urandom_range(1, D - 1), 1'b1, 1'b1);
                1, 2: single(k, $urandom_range(D, J - 1), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)));
                3: single(k, $urandom_range(J + 1, J + 10), 1'b1, 1'b1);
                default: begin
                    if ($urandom_range(0, 1) == 0) collide($urandom_range(1, 8));
                    else offset(k, $urandom_range(1, D + 3), $urandom_range(1, 3),
                                $urandom_range(1, 3));
                end
            endcase
        end

        drain("final_pending");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
